rr_sel_arbiter: RTL and testbench

RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

---
 rtl/rr_sel_arbiter.sv | 75 +++++++
 tb/tb_rr_sel_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin 4-source arbiter driving a 4:1 mux select, with hold-time limit
module rr_sel_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d, ptr_q, ptr_d, win;
    logic [3:0]  grant_q, grant_d;
    logic        busy_q, busy_d, timeout_q, timeout_d;
    logic [7:0]  hold_q, hold_d;
    // scan downward so the set bit closest to ptr is the last one written
    always_comb begin
        win = ptr_q;
        for (int i = 3; i >= 0; i--)
            if (req[ptr_q + 2'(i)]) win = ptr_q + 2'(i);
    end
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        if (state_q == IDLE) begin
            if (|req) begin
                state_d = GRANT;
                sel_d   = win;
                grant_d = 4'b0001 << win;
                busy_d  = 1'b1;
                hold_d  = 8'd0;
            end
        end else if (done || hold_q == 8'(MAX_HOLD - 1)) begin
            state_d   = IDLE;
            grant_d   = 4'b0000;
            busy_d    = 1'b0;
            ptr_d     = sel_q + 2'd1;
            timeout_d = !done;
        end else begin
            hold_d = hold_q + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            grant_q   <= 4'b0000;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= 2'd0;
            hold_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end
    assign sel     = sel_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: directed vector table plus a hand-written timeout sequence
module tb_rr_sel_arbiter;
    logic       clk = 1'b0, rst = 1'b1, done = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy, timeout;
    int         nvec = 0, nerr = 0, n;
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [1:0] sel;
        logic [3:0] grant;
        logic       busy;
        logic       tmo;
    } vec_t;
    vec_t v[29];
    rr_sel_arbiter #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .sel(sel), .grant(grant), .busy(busy), .timeout(timeout)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    initial begin
        // rst req done | sel grant busy timeout
        v[0]  = '{1'b1, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        v[1]  = '{1'b0, 4'b1010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
        v[2]  = '{1'b0, 4'b0000, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
        v[3]  = '{1'b0, 4'b1000, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
        v[4]  = '{1'b0, 4'b1000, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0};
        v[5]  = '{1'b0, 4'b1010, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
        v[6]  = '{1'b0, 4'b1010, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0};
        v[7]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        v[8]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        v[9]  = '{1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        v[10] = '{1'b0, 4'b1111, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
        v[11] = '{1'b0, 4'b1111, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0};
        v[12] = '{1'b0, 4'b1111, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        v[13] = '{1'b0, 4'b1111, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0};
        v[14] = '{1'b0, 4'b1111, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
        v[15] = '{1'b0, 4'b1111, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0};
        v[16] = '{1'b0, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        v[17] = '{1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        v[18] = '{1'b0, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        v[19] = '{1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        v[20] = '{1'b1, 4'b0100, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        v[21] = '{1'b0, 4'b0101, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        v[22] = '{1'b0, 4'b0101, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        v[23] = '{1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        v[24] = '{1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        v[25] = '{1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        v[26] = '{1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        v[27] = '{1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0};
        v[28] = '{1'b0, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
        for (int i = 0; i < 29; i++) begin
            rst = v[i].rst; req = v[i].req; done = v[i].done;
            step();
            check($sformatf("vec%0d {sel,grant,busy,timeout}", i),
                  32'({sel, grant, busy, timeout}),
                  32'({v[i].sel, v[i].grant, v[i].busy, v[i].tmo}));
        end
        // forced release: ptr is 3 here, so source 2 wins and is held MAX_HOLD cycles
        req = 4'b0100; done = 1'b0; n = 0;
        step();
        while (busy && n < 10) begin
            check("held grant", 32'({sel, grant}), 32'({2'd2, 4'b0100}));
            check("held timeout", 32'(timeout), 32'd0);
            n++;
            step();
        end
        check("hold length", 32'(n), 32'd4);
        check("release {busy,grant,timeout}", 32'({busy, grant, timeout}), 32'({1'b0, 4'b0000, 1'b1}));
        step();
        check("regrant after idle {sel,busy,timeout}", 32'({sel, busy, timeout}), 32'({2'd2, 1'b1, 1'b0}));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
